// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking and per-frame input capture.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  state_t           state_q, state_d;
  logic [15:0]      shadow_bcd_q;
  logic [3:0]       shadow_dp_q;
  logic             wrap, frame_end;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q;
  logic [3:0]       nib;
  logic             suppress;

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b0111111;
    endcase
  endfunction

  // The FSM state tracks the counter value it will hold, so state_q always matches cnt_q.
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    frame_end = wrap && (dig_q == 2'd3);
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
    dig_d     = wrap ? dig_q + 2'd1 : dig_q;
    state_d   = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    case (dig_q)
      2'd0:    nib = shadow_bcd_q[3:0];
      2'd1:    nib = shadow_bcd_q[7:4];
      2'd2:    nib = shadow_bcd_q[11:8];
      default: nib = shadow_bcd_q[15:12];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (dig_q)
      2'd3:    suppress = (shadow_bcd_q[15:12] == 4'd0);
      2'd2:    suppress = (shadow_bcd_q[15:8] == 8'd0);
      2'd1:    suppress = (shadow_bcd_q[15:4] == 12'd0);
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_q == ST_SHOW && !suppress) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = seg_enc(nib);
      dp_d  = ~shadow_dp_q[dig_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      state_q      <= ST_BLANK;
      shadow_bcd_q <= 16'd0;
      shadow_dp_q  <= 4'd0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= 4'b1111;
      tick_q       <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= frame_end;
      if (frame_end) begin
        shadow_bcd_q <= bcd_in;
        shadow_dp_q  <= dp_in;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  seg7_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

  task step_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task restart(input logic [15:0] b, input logic [3:0] d);
    @(negedge clk);
    reset  = 1'b1;
    bcd_in = b;
    dp_in  = d;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task test_reset;
    int ks[4];
    logic [11:0] ex[4];
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_tick} !== {BLANK, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", {an, seg, dp, frame_tick}, {BLANK, 1'b0});
    end
    reset = 1'b0;
    k = 0;
    step_to(5);
    n_cmp++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      n_err++;
      $display("FAIL first_frame_zero: got %b want %b", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame_tick} !== {BLANK, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %b want %b", {an, seg, dp, frame_tick}, {BLANK, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    ks = '{0, 1, 2, 3};
    ex = '{BLANK, BLANK, BLANK, {4'b1110, 7'b1000000, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      step_to(ks[i]);
      n_cmp++;
      if ({an, seg, dp} !== ex[i]) begin
        n_err++;
        $display("FAIL post_reset k=%0d: got %b want %b", k, {an, seg, dp}, ex[i]);
      end
    end
  endtask

  task test_digits_0059;
    int ks[5];
    logic [11:0] ex[5];
    int cnt0, cnt1, bad_hot;
    restart(16'h0059, 4'b0000);
    ks = '{34, 35, 43, 51, 59};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ex = '{BLANK, {4'b1110, 7'b0010000, 1'b1}, {4'b1101, 7'b0010010, 1'b1}, BLANK, BLANK};
`else
    ex = '{BLANK, {4'b1110, 7'b0010000, 1'b1}, {4'b1101, 7'b0010010, 1'b1},
           {4'b1011, 7'b1000000, 1'b1}, {4'b0111, 7'b1000000, 1'b1}};
`endif
    for (int i = 0; i < 5; i++) begin
      step_to(ks[i]);
      n_cmp++;
      if ({an, seg, dp} !== ex[i]) begin
        n_err++;
        $display("FAIL digits_0059 k=%0d: got %b want %b", k, {an, seg, dp}, ex[i]);
      end
    end
    cnt0 = 0; cnt1 = 0; bad_hot = 0;
    for (int t = 65; t <= 96; t++) begin
      step_to(t);
      if (an == 4'b1110) cnt0++;
      if (an == 4'b1101) cnt1++;
      if ($countones(~an) > 1) bad_hot++;
    end
    n_cmp++;
    if (cnt0 !== 6) begin
      n_err++;
      $display("FAIL enable_len_d0: got %0d want 6", cnt0);
    end
    n_cmp++;
    if (cnt1 !== 6) begin
      n_err++;
      $display("FAIL enable_len_d1: got %0d want 6", cnt1);
    end
    n_cmp++;
    if (bad_hot !== 0) begin
      n_err++;
      $display("FAIL one_hot_an: got %0d multi-enable cycles want 0", bad_hot);
    end
  endtask

  task test_zero_value;
    int ks[3];
    logic [11:0] ex[3];
    restart(16'h0000, 4'b0000);
    ks = '{35, 43, 59};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ex = '{{4'b1110, 7'b1000000, 1'b1}, BLANK, BLANK};
`else
    ex = '{{4'b1110, 7'b1000000, 1'b1}, {4'b1101, 7'b1000000, 1'b1}, {4'b0111, 7'b1000000, 1'b1}};
`endif
    for (int i = 0; i < 3; i++) begin
      step_to(ks[i]);
      n_cmp++;
      if ({an, seg, dp} !== ex[i]) begin
        n_err++;
        $display("FAIL zero_value k=%0d: got %b want %b", k, {an, seg, dp}, ex[i]);
      end
    end
  endtask

  task test_midframe_change;
    logic [10:0] ex;
    logic        chk;
    restart(16'h1234, 4'b0000);
    for (int t = 1; t <= 96; t++) begin
      step_to(t);
      n_cmp++;
      if (frame_tick !== ((t % 32) == 0)) begin
        n_err++;
        $display("FAIL frame_tick k=%0d: got %b want %b", t, frame_tick, ((t % 32) == 0));
      end
      chk = 1'b1;
      case (t)
        35:      ex = {4'b1110, 7'b0011001};
        43:      ex = {4'b1101, 7'b0110000};
        51:      ex = {4'b1011, 7'b0100100};
        59:      ex = {4'b0111, 7'b1111001};
        67:      ex = {4'b1110, 7'b0000000};
        75:      ex = {4'b1101, 7'b1111000};
        83:      ex = {4'b1011, 7'b0000010};
        91:      ex = {4'b0111, 7'b0010010};
        default: begin ex = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_cmp++;
        if ({an, seg} !== ex) begin
          n_err++;
          $display("FAIL midframe k=%0d: got %b want %b", t, {an, seg}, ex);
        end
      end
      if (t == 44) bcd_in = 16'h5678;
    end
  endtask

  task test_dash_dp;
    int ks[4];
    logic [11:0] ex[4];
    restart(16'h00A0, 4'b0010);
    ks = '{35, 43, 51, 59};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ex = '{{4'b1110, 7'b1000000, 1'b1}, {4'b1101, 7'b0111111, 1'b0}, BLANK, BLANK};
`else
    ex = '{{4'b1110, 7'b1000000, 1'b1}, {4'b1101, 7'b0111111, 1'b0},
           {4'b1011, 7'b1000000, 1'b1}, {4'b0111, 7'b1000000, 1'b1}};
`endif
    for (int i = 0; i < 4; i++) begin
      step_to(ks[i]);
      n_cmp++;
      if ({an, seg, dp} !== ex[i]) begin
        n_err++;
        $display("FAIL dash_dp k=%0d: got %b want %b", k, {an, seg, dp}, ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits_0059();
    test_zero_value();
    test_midframe_change();
    test_dash_dp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
